struct_data_arbiter: RTL
========================

Name: struct_data_arbiter

Overview:
- Round-robin arbiter sharing one 8-bit output data register between N requesters; drives o_a.
- Output register is an unpacked struct entry (members data and src), so member-level visibility of record signals survives synthesis for emulation.
- Sits between requester-side producers and the single o_a consumer; adds a burst lock so one requester can hold the resource for consecutive beats.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, data width of the struct data member and of o_a.
- BURST_LEN, 2, maximum consecutive accepted beats per grant (>=1).
- SRC_W, $clog2(N_REQ), width of the struct src member (derived; not overridden).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  N_REQ  per-requester valid.
- i_req_data  input  N_REQ*W  packed requester data; requester k occupies bits [k*W +: W].
- o_req_ready  output  N_REQ  per-requester ready, at most one bit set.
- o_a  output  W  struct data member.
- o_a_src  output  SRC_W  struct src member (index of the requester that wrote it).
- o_a_valid  output  1  output register holds an entry.
- i_a_ready  input  1  consumer accepts the entry.

Behaviour:
- Reset (async assert, sync release): o_a=0, o_a_src=0, o_a_valid=0, state=IDLE, burst_cnt=0, last_grant=N_REQ-1 (requester 0 has first priority).
- slot_free = !o_a_valid | i_a_ready.
- o_req_ready[k] = slot_free & (grant==k) & i_req_valid[k]. Combinational; no other bit is set.
- Accept when o_req_ready[k]=1.
  - Next edge: o_a<=data_k, o_a_src<=k, o_a_valid<=1.
  - Latency is 1 cycle from accept to o_a_valid.
  - Throughput is 1 beat/cycle when i_a_ready is held high.
- Drain without accept: o_a_valid<=0; o_a and o_a_src hold their last values.
- o_a_valid=1 & i_a_ready=0: entry and all outputs stay stable.
- FSM:
  - IDLE: grant is the round-robin pick, starting at last_grant+1 and wrapping modulo N_REQ.
    - On accept: last_grant<=k, burst_cnt<=1.
    - Go to OWN if BURST_LEN>1; otherwise stay in IDLE.
  - OWN: grant=last_grant, and other requesters are blocked.
    - On accept, burst_cnt++.
    - Go to IDLE when burst_cnt reaches BURST_LEN, or when i_req_valid[last_grant]=0 while slot_free=1 (owner released).
    - Owner valid low while slot not free: stay in OWN; the consumer stall does not forfeit the lock.
- No valid requesters in IDLE: grant holds, no ready, last_grant unchanged.
- i_rst mid-transfer: pending entry discarded, FSM forced to IDLE, no ready asserted while i_rst=1.
- Requester must hold valid/data stable until ready; the arbiter does not check this.

Optional Feature:
- Macro STRUCT_ARB_PARITY_EN.
- Defined:
  - Struct gains member par = ^data, captured with data.
  - Extra output o_a_par (1 bit), reset 0.
  - The same cycle as o_a_valid, it equals even parity of o_a.
- Undefined: no par member and no o_a_par port; all other behaviour identical.

Decomposition:
- Package struct_arb_pkg:
  - typedef of the unpacked struct arb_entry_t {data, src, par under macro};
  - state enum arb_state_e {IDLE, OWN};
  - width constants W_DEF=8, N_REQ_DEF=4.
- One sub-module rr_pick: combinational round-robin picker (inputs req vector, last index; outputs one-hot grant and index, any flag).

Test Plan:
- Single beat: reset, i_req_valid=4'b0100, data2=8'hA5, i_a_ready=1 -> o_req_ready=4'b0100 same cycle; next cycle o_a=8'hA5, o_a_src=2, o_a_valid=1.
- Round robin, BURST_LEN=1: all four valid constantly, i_a_ready=1 -> o_a_src sequence 0,1,2,3,0 on consecutive cycles.
- Burst lock, BURST_LEN=2: req0 and req1 always valid -> src sequence 0,0,1,1,0,0; req1 never ready during req0's burst.
- Backpressure: o_a_valid=1, i_a_ready=0 for 3 cycles with req3 valid -> o_a unchanged, o_req_ready=0; on i_a_ready=1, req3 accepted the same cycle.
- Early release: req0 drops valid after 1 of 2 beats while req2 valid -> FSM to IDLE, next grant is 2.
- Async reset mid-burst: assert i_rst between edges -> o_a_valid=0, o_a=0 immediately; after release the first grant goes to requester 0. With STRUCT_ARB_PARITY_EN and data 8'h07, o_a_par=1.

Source files
------------

// File: rtl/struct_arb_pkg.sv
// Shared types for struct_data_arbiter: output-entry record, FSM states, default widths.
// The par member exists only when STRUCT_ARB_PARITY_EN is defined.
package struct_arb_pkg;

  localparam int W_DEF     = 8;
  localparam int N_REQ_DEF = 4;
  localparam int SRC_W_DEF = $clog2(N_REQ_DEF);

  typedef enum logic {
    IDLE,
    OWN
  } arb_state_e;

  // Record members stay individually visible after synthesis for emulation probes
  typedef struct {
    logic [W_DEF-1:0]     data;
    logic [SRC_W_DEF-1:0] src;
`ifdef STRUCT_ARB_PARITY_EN
    logic                 par;
`endif
  } arb_entry_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches from last+1 upward, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [SRC_W-1:0] idx,
  output logic             any
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last) + i) % N_REQ;
      if (!any && req[k]) begin
        any      = 1'b1;
        idx      = SRC_W'(k);
        grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/struct_data_arbiter.sv
// Round-robin arbiter with burst lock feeding one struct-typed output register.
// Optional STRUCT_ARB_PARITY_EN adds a parity member and the o_a_par port.
module struct_data_arbiter
  import struct_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int W         = W_DEF,
  parameter int BURST_LEN = 2,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ*W-1:0] i_req_data,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [W-1:0]       o_a,
  output logic [SRC_W-1:0]   o_a_src,
`ifdef STRUCT_ARB_PARITY_EN
  output logic               o_a_par,
`endif
  output logic               o_a_valid,
  input  logic               i_a_ready
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0] last_q, last_d;
  arb_entry_t       entry_q, entry_d;
  logic             valid_q, valid_d;

  logic             slot_free;
  logic             accept;
  logic [SRC_W-1:0] grant_idx;
  logic [W-1:0]     sel_data;
  logic [N_REQ-1:0] pick_grant;
  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;

  assign slot_free = !valid_q || i_a_ready;

  rr_pick #(.N_REQ(N_REQ), .SRC_W(SRC_W)) u_pick (
    .req   (i_req_valid),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_W'(N_REQ - 1);
      entry_q <= '{default: '0};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_d  = pick_idx;
          cnt_d   = CNT_W'(1);
          state_d = (BURST_LEN > 1) ? OWN : IDLE;
        end
      end
      OWN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (int'(cnt_q) + 1 >= BURST_LEN) state_d = IDLE;
        end else if (slot_free && !i_req_valid[last_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled consumer keeps the owner locked even if its valid drops
  always_comb begin
    o_req_ready = '0;
    accept      = 1'b0;
    grant_idx   = last_q;
    if (state_q == IDLE) grant_idx = pick_idx;
    if (!i_rst && slot_free) begin
      if (state_q == IDLE) begin
        accept      = pick_any;
        o_req_ready = pick_grant;
      end else begin
        accept              = i_req_valid[last_q];
        o_req_ready[last_q] = i_req_valid[last_q];
      end
    end
    sel_data = i_req_data[int'(grant_idx)*W +: W];
    entry_d  = entry_q;
    valid_d  = valid_q;
    if (accept) begin
      entry_d.data = W_DEF'(sel_data);
      entry_d.src  = SRC_W_DEF'(grant_idx);
`ifdef STRUCT_ARB_PARITY_EN
      entry_d.par  = ^sel_data;
`endif
      valid_d      = 1'b1;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  assign o_a       = W'(entry_q.data);
  assign o_a_src   = SRC_W'(entry_q.src);
  assign o_a_valid = valid_q;
`ifdef STRUCT_ARB_PARITY_EN
  assign o_a_par   = entry_q.par;
`endif

endmodule
